sap_run_controller: RTL and testbench

//  Sequences the SAP-1 core in the top level. It produces the core's single-cycle clock-enable and the core's reset.
//  It supports four actions: free-run at a prescaled rate, single-step one instruction, pause on a PC breakpoint,
//  and load a 16-byte program into core RAM from a host byte stream.
//  It sits between the top-level pins and the cpu core, and owns the RAM write port while loading.

---
 rtl/sap_run_controller.sv | 188 ++++++++++++++++++
 tb/tb_sap_run_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_run_controller.sv
// Run controller for the SAP-1 core: free-run prescaler, single-step, PC breakpoint
// and a 16-byte program loader that owns the RAM write port while loading.
module sap_run_controller #(
  parameter int DIV_W  = 19,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic [2:0]        cpu_stage,
  output logic              cpu_ce,
  output logic              cpu_rst,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_PAUSED = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [1:0]        OP_RUN    = 2'b00;
  localparam logic [1:0]        OP_STEP   = 2'b01;
  localparam logic [1:0]        OP_PAUSE  = 2'b10;
  localparam logic [1:0]        OP_LOAD   = 2'b11;
  localparam logic [2:0]        STG_BOUND = 3'd0;
  localparam logic [2:0]        STG_HALT  = 3'd6;
  localparam logic [2:0]        STEP_MAX  = 3'd7;
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = {DIV_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_e            state_r, state_s;
  logic [DIV_W-1:0]  div_r, div_s;
  logic              skip_bp_r, skip_bp_s;
  logic              step_gap_r, step_gap_s;
  logic [2:0]        step_cnt_r, step_cnt_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic              hold_r, hold_s;
  logic              cpu_ce_r, cpu_ce_s;
  logic              cpu_rst_r, cpu_rst_s;
  logic              ram_we_r, ram_we_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_r, ram_wdata_s;
  logic              cmd_acc_s, tick_s, bp_hit_s, load_exit_s;

  assign cmd_ready = (state_r == ST_PAUSED) || (state_r == ST_RUN) || (state_r == ST_HALTED);
  assign ld_ready  = (state_r == ST_LOAD);
  assign cmd_acc_s = cmd_valid && cmd_ready;
  assign tick_s    = (div_r == DIV_LAST);
  assign bp_hit_s  = bp_en && (cpu_stage == STG_BOUND) && (cpu_pc == bp_addr);

  assign cpu_ce    = cpu_ce_r;
  assign cpu_rst   = cpu_rst_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign state     = state_r;

  // Next-state and next-output decode for all operating modes.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    skip_bp_s   = skip_bp_r;
    step_gap_s  = step_gap_r;
    step_cnt_s  = step_cnt_r;
    idx_s       = idx_r;
    cpu_ce_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    case (state_r)
      ST_PAUSED, ST_HALTED: begin
        if (cmd_acc_s && (cmd_op == OP_LOAD)) begin
          state_s    = ST_LOAD;
          idx_s      = {ADDR_W{1'b0}};
          ram_addr_s = {ADDR_W{1'b0}};
        end else if (cmd_acc_s && (state_r == ST_PAUSED) && (cmd_op == OP_RUN)) begin
          state_s   = ST_RUN;
          div_s     = {DIV_W{1'b0}};
          skip_bp_s = 1'b1;
        end else if (cmd_acc_s && (state_r == ST_PAUSED) && (cmd_op == OP_STEP)) begin
          state_s    = ST_STEP;
          step_gap_s = 1'b0;
          step_cnt_s = 3'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        div_s = div_r + DIV_ONE;
        if (cmd_acc_s && (cmd_op == OP_PAUSE)) begin
          state_s = ST_PAUSED;
        end else if (cpu_stage == STG_HALT) begin
          state_s = ST_HALTED;
        end else if (tick_s && bp_hit_s && !skip_bp_r) begin
          state_s = ST_PAUSED;
        end else if (tick_s) begin
          cpu_ce_s  = 1'b1;
          skip_bp_s = (cpu_stage == STG_BOUND) ? 1'b0 : skip_bp_r;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STEP: begin
        // The stage seen at the end of a gap cycle already reflects the preceding pulse.
        if (step_gap_r) begin
          step_gap_s = 1'b0;
        end else if (cpu_stage == STG_HALT) begin
          state_s = ST_HALTED;
        end else if ((step_cnt_r != 3'd0) && (cpu_stage == STG_BOUND)) begin
          state_s = ST_PAUSED;
        end else if (step_cnt_r == STEP_MAX) begin
          state_s = ST_PAUSED;
        end else begin
          cpu_ce_s   = 1'b1;
          step_cnt_s = step_cnt_r + 3'd1;
          step_gap_s = 1'b1;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          ram_we_s    = 1'b1;
          ram_wdata_s = ld_data;
          ram_addr_s  = idx_r;
          idx_s       = idx_r + ADDR_ONE;
          state_s     = (idx_r == ADDR_LAST) ? ST_PAUSED : ST_LOAD;
        end else begin
          ram_we_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_PAUSED;
      end
    endcase
    // Core reset covers the whole load plus one cycle past the final write.
    load_exit_s = (state_r == ST_LOAD) && (state_s != ST_LOAD);
    hold_s      = load_exit_s;
    cpu_rst_s   = (state_s == ST_LOAD) || load_exit_s || hold_r;
  end

  // State and registered outputs; the enable is masked whenever the core is held in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_PAUSED;
      div_r       <= {DIV_W{1'b0}};
      skip_bp_r   <= 1'b0;
      step_gap_r  <= 1'b0;
      step_cnt_r  <= 3'd0;
      idx_r       <= {ADDR_W{1'b0}};
      hold_r      <= 1'b0;
      cpu_ce_r    <= 1'b0;
      cpu_rst_r   <= 1'b1;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      skip_bp_r   <= skip_bp_s;
      step_gap_r  <= step_gap_s;
      step_cnt_r  <= step_cnt_s;
      idx_r       <= idx_s;
      hold_r      <= hold_s;
      cpu_ce_r    <= cpu_ce_s && !cpu_rst_s;
      cpu_rst_r   <= cpu_rst_s;
      ram_we_r    <= ram_we_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
    end
  end

endmodule

// File: tb/tb_sap_run_controller.sv
// Self-checking bench for sap_run_controller with a small SAP-1 core model (DIV_W=3).
module tb_sap_run_controller;

  localparam logic [1:0] OP_RUN = 2'b00, OP_STEP = 2'b01, OP_PAUSE = 2'b10, OP_LOAD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [3:0] cpu_pc;
  logic [2:0] cpu_stage;
  logic       cpu_ce;
  logic       cpu_rst;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [2:0] state;

  sap_run_controller #(.DIV_W(3), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .bp_en(bp_en), .bp_addr(bp_addr),
    .cpu_pc(cpu_pc), .cpu_stage(cpu_stage), .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .state(state)
  );

  always #5 clk = ~clk;

  // Core model: stage 0..5 advances on each enable, PC increments when an instruction completes.
  logic [2:0] m_stage;
  logic [3:0] m_pc;
  logic       m_halt;
  always @(posedge clk) begin
    if (cpu_rst === 1'b1) begin
      m_stage <= 3'd0;
      m_pc    <= 4'd0;
    end else if (cpu_ce === 1'b1) begin
      if (m_stage == 3'd5) begin
        m_stage <= 3'd0;
        m_pc    <= m_pc + 4'd1;
      end else begin
        m_stage <= m_stage + 3'd1;
      end
    end
  end
  assign cpu_stage = m_halt ? 3'd6 : m_stage;
  assign cpu_pc    = m_pc;

  // Observers: RAM image, write log, enable count, enable-during-reset violations.
  logic [7:0] mem [16];
  logic [3:0] q_addr[$];
  int wcount = 0, ce_count = 0, viol = 0;
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      mem[ram_addr] = ram_wdata;
      q_addr.push_back(ram_addr);
      wcount++;
    end
    if (cpu_ce === 1'b1) ce_count++;
    if ((cpu_ce === 1'b1) && (cpu_rst === 1'b1)) viol++;
  end

  int checks = 0, failures = 0;
  logic [7:0] prog [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    step();
    cmd_valid = 1'b0;
  endtask

  // Feeds prog[0..15]; optional fixed gap before byte index gap_at, or random gaps.
  task automatic load_prog(input bit rnd_gaps, input int gap_at, input int gap_len);
    int n = 0;
    int it = 0;
    q_addr.delete();
    while (n < 16 && it < 200) begin
      it++;
      if (n == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          ld_valid = 1'b0;
          step();
          chk("ld_gap_we", ram_we, 0);
        end
        gap_at = -1;
      end
      if (rnd_gaps && ($urandom_range(0, 2) == 0)) begin
        ld_valid = 1'b0;
        step();
      end else begin
        chk("ld_ready", ld_ready, 1);
        ld_valid = 1'b1;
        ld_data  = prog[n];
        n++;
        step();
      end
    end
    ld_valid = 1'b0;
    chk("load_budget", n, 16);
  endtask

  task automatic post_load();
    chk("ld_done_state", state, 0);
    chk("ld_last_we", ram_we, 1);
    chk("ld_last_rst", cpu_rst, 1);
    chk("ld_ready_off", ld_ready, 0);
    step();
    chk("ld_hold_rst", cpu_rst, 1);
    chk("ld_after_we", ram_we, 0);
    step();
    chk("ld_rst_drop", cpu_rst, 0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), mem[i], prog[i]);
  endtask

  // Single step: pulses every 2 clk, count set by distance to the next boundary.
  task automatic do_step(input int exp_pulses);
    int pulses = 0, last = -1, bad = 0, k = 0;
    send_cmd(OP_STEP);
    chk("step_enter", state, 2);
    while (state == 3'd2 && k < 40) begin
      k++;
      step();
      if (cpu_ce) begin
        if (last >= 0 && (k - last) != 2) bad++;
        last = k;
        pulses++;
      end
    end
    chk("step_pulses", pulses, exp_pulses);
    chk("step_spacing", bad, 0);
    chk("step_exit", state, 0);
  endtask

  typedef struct {
    logic       cv;
    logic [1:0] op;
    logic       lv;
    logic [2:0] st;
    logic       rdy;
    logic       ldr;
    logic       we;
    logic       rst;
    logic       ce;
  } vec_t;
  vec_t vt [10];

  initial begin
    int n, ce0, wc0, k, exp_p;
    vt[0] = '{1'b1, OP_PAUSE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, OP_RUN,   1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, OP_RUN,   1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, OP_RUN,   1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, OP_RUN,   1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, OP_STEP,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b1, OP_LOAD,  1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b1, OP_PAUSE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b1, OP_LOAD,  1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9] = '{1'b1, OP_RUN,   1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_PAUSE; ld_valid = 1'b0; ld_data = 8'h00;
    bp_en = 1'b0; bp_addr = 4'd0; m_halt = 1'b0;

    // T1 reset
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_ce", cpu_ce, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    rst_n = 1'b1;
    chk("rst_release_hold", cpu_rst, 1);
    step();
    chk("rst_release_drop", cpu_rst, 0);

    // Command acceptance table; ends in LOAD
    for (int i = 0; i < 10; i++) begin
      cmd_valid = vt[i].cv; cmd_op = vt[i].op; ld_valid = vt[i].lv; ld_data = 8'hAA;
      step();
      chk($sformatf("tbl%0d_state", i), state, vt[i].st);
      chk($sformatf("tbl%0d_cmd_ready", i), cmd_ready, vt[i].rdy);
      chk($sformatf("tbl%0d_ld_ready", i), ld_ready, vt[i].ldr);
      chk($sformatf("tbl%0d_we", i), ram_we, vt[i].we);
      chk($sformatf("tbl%0d_cpu_rst", i), cpu_rst, vt[i].rst);
      chk($sformatf("tbl%0d_ce", i), cpu_ce, vt[i].ce);
    end
    cmd_valid = 1'b0; ld_valid = 1'b0;

    // T2 load with a 3-cycle gap after byte 5
    prog = '{8'h1F, 8'h2E, 8'h4F, 8'h7B, 8'hE0, 8'h1E, 8'h2F, 8'h4E,
             8'h7B, 8'hE0, 8'h60, 8'hF0, 8'h00, 8'h00, 8'h01, 8'h00};
    wc0 = wcount;
    load_prog(1'b0, 5, 3);
    post_load();
    chk("t2_wcount", wcount - wc0, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("t2_addr%0d", i), (i < q_addr.size()) ? q_addr[i] : 4'hx, i);
    check_mem("t2");

    // T3 run rate, then PAUSE on a tick cycle
    send_cmd(OP_RUN);
    chk("t3_enter", state, 1);
    for (k = 1; k < 32; k++) begin
      step();
      chk($sformatf("t3_ce_k%0d", k), cpu_ce, (k % 8) == 0);
    end
    send_cmd(OP_PAUSE);
    chk("t3_pause_ce", cpu_ce, 0);
    chk("t3_pause_state", state, 0);

    // T4 step: first to the boundary from mid-instruction, then one full instruction
    exp_p = (m_stage == 3'd0) ? 6 : 6 - int'(m_stage);
    do_step(exp_p);
    do_step(6);

    // T5 breakpoint at PC 3
    bp_en = 1'b1; bp_addr = 4'd3;
    send_cmd(OP_RUN);
    n = 0;
    while (state == 3'd1 && n < 400) begin step(); n++; end
    chk("t5_paused", state, 0);
    chk("t5_hit_ce", cpu_ce, 0);
    chk("t5_pc", cpu_pc, 3);
    chk("t5_stage", cpu_stage, 0);
    send_cmd(OP_RUN);
    n = 0;
    while (m_pc != 4'd4 && n < 400) begin step(); n++; end
    chk("t5_passed_pc", m_pc, 4);
    chk("t5_still_run", state, 1);
    send_cmd(OP_PAUSE);
    chk("t5_pause", state, 0);
    bp_en = 1'b0;

    // T6 halt
    send_cmd(OP_RUN);
    for (int i = 0; i < 5; i++) step();
    m_halt = 1'b1;
    step();
    chk("t6_halted", state, 4);
    ce0 = ce_count;
    for (int i = 0; i < 20; i++) step();
    chk("t6_no_ce", ce_count - ce0, 0);
    chk("t6_ready", cmd_ready, 1);
    send_cmd(OP_RUN);   chk("t6_run_ign", state, 4);
    send_cmd(OP_STEP);  chk("t6_step_ign", state, 4);
    send_cmd(OP_PAUSE); chk("t6_pause_ign", state, 4);
    send_cmd(OP_LOAD);  chk("t6_load", state, 3);
    m_halt = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    load_prog(1'b1, -1, 0);
    post_load();
    check_mem("t6");

    // Randomized loads with random gaps against the RAM image
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      wc0 = wcount;
      send_cmd(OP_LOAD);
      chk("rl_enter", state, 3);
      load_prog(1'b1, -1, 0);
      post_load();
      chk("rl_wcount", wcount - wc0, 16);
      check_mem($sformatf("rl%0d", r));
    end

    // Randomized RUN windows: ticks strictly before the PAUSE cycle each give one enable
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(2, 40);
      send_cmd(OP_RUN);
      ce0 = ce_count;
      for (int i = 1; i < n; i++) step();
      send_cmd(OP_PAUSE);
      chk($sformatf("rr%0d_ce_n%0d", r, n), ce_count - ce0, (n - 1) / 8);
      chk("rr_state", state, 0);
    end

    // Reset in the middle of a load abandons it
    send_cmd(OP_LOAD);
    k = $urandom_range(1, 10);
    wc0 = wcount;
    for (int i = 0; i < k; i++) begin ld_valid = 1'b1; ld_data = 8'(i); step(); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ld_valid = 1'b0;
    chk("mrst_wcount", wcount - wc0, k);
    chk("mrst_state", state, 0);
    chk("mrst_we", ram_we, 0);
    chk("mrst_cpu_rst", cpu_rst, 0);

    chk("ce_during_rst", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
